md_pad_scanner: RTL and testbench

- Scans one DB9 joystick port. Handles both plain Atari-style sticks and Sega Mega Drive 3- and 6-button pads.
- Drives the pad SELECT line through the standard 8-phase Mega Drive sequence and assembles the buttons into a registered, frame-atomic snapshot.
- Sits directly upstream of the joystick protocol mapper. joy_out feeds its db9joy1_in / db9joy2_in inputs (6-bit, active-low, FUDLR order).
- Extra buttons (A, Start, X, Y, Z, Mode) go on separate outputs for keymapping logic.

---
 rtl/md_pad_scanner.sv | 161 ++++++++++++++++
 tb/tb_md_pad_scanner.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/md_pad_scanner.sv
// DB9 joystick port scanner for plain Atari-style sticks and Mega Drive
// 3/6-button pads. Runs the 8-phase SELECT sequence once per frame, samples
// each phase on its last cycle, and commits a frame-atomic snapshot at the
// end of PH7.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | select high between frames so the pad's internal counter resets
// PH0   | select high; sample U, D, L, R, B (pin6), C (pin9)
// PH1   | select low; sample A (pin6), Start (pin9); L=R=0 flags an MD pad
// PH2   | select high; no sampling
// PH3   | select low; no sampling
// PH4   | select high; no sampling
// PH5   | select low; U=D=L=R=0 flags a 6-button pad
// PH6   | select high; sample Z/Y/X/Mode on up/down/left/right
// PH7   | select low; commit snapshot on exit, then back to IDLE

module md_pad_scanner #(
    parameter int PHASE_CYCLES = 280,
    parameter int IDLE_CYCLES  = 56000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] joy_raw,
    output logic       joy_select,
    output logic [5:0] joy_out,
    output logic       joy_start,
    output logic       joy_a,
    output logic [3:0] joy_xyzm,
    output logic       is_md,
    output logic       is_6button,
    output logic       frame_done
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_PH0,
        S_PH1,
        S_PH2,
        S_PH3,
        S_PH4,
        S_PH5,
        S_PH6,
        S_PH7
    } state_t;

    localparam logic [16:0] PHASE_LOAD = 17'(PHASE_CYCLES - 1);
    localparam logic [16:0] IDLE_LOAD  = 17'(IDLE_CYCLES - 1);

    state_t      state;
    logic [16:0] cnt;
    logic [5:0]  sync1;
    logic [5:0]  sync2;

    // Shadow registers hold this frame's samples until the commit.
    logic [5:0]  sh_std;
    logic        sh_a;
    logic        sh_start;
    logic [3:0]  sh_xyzm;
    logic        md_flag;
    logic        six_flag;

    // Two-flop synchroniser for the asynchronous pad pins (idle level is high).
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 6'h3F;
            sync2 <= 6'h3F;
        end else begin
            sync1 <= joy_raw;
            sync2 <= sync1;
        end
    end

    // Phase sequencer: down-counter per state, sample on the terminal count,
    // drive SELECT for the state being entered, commit on PH7 exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= IDLE_LOAD;
            joy_select <= 1'b1;
            sh_std     <= 6'h3F;
            sh_a       <= 1'b1;
            sh_start   <= 1'b1;
            sh_xyzm    <= 4'hF;
            md_flag    <= 1'b0;
            six_flag   <= 1'b0;
            joy_out    <= 6'h3F;
            joy_start  <= 1'b1;
            joy_a      <= 1'b1;
            joy_xyzm   <= 4'hF;
            is_md      <= 1'b0;
            is_6button <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (cnt != 17'd0) begin
                cnt <= cnt - 17'd1;
            end else begin
                cnt <= PHASE_LOAD;
                case (state)
                    S_IDLE: begin
                        state      <= S_PH0;
                        joy_select <= 1'b1;
                    end
                    S_PH0: begin
                        sh_std     <= sync2;
                        state      <= S_PH1;
                        joy_select <= 1'b0;
                    end
                    S_PH1: begin
                        sh_a       <= sync2[4];
                        sh_start   <= sync2[5];
                        md_flag    <= ~sync2[1] & ~sync2[0];
                        state      <= S_PH2;
                        joy_select <= 1'b1;
                    end
                    S_PH2: begin
                        state      <= S_PH3;
                        joy_select <= 1'b0;
                    end
                    S_PH3: begin
                        state      <= S_PH4;
                        joy_select <= 1'b1;
                    end
                    S_PH4: begin
                        state      <= S_PH5;
                        joy_select <= 1'b0;
                    end
                    S_PH5: begin
                        six_flag   <= (sync2[3:0] == 4'h0);
                        state      <= S_PH6;
                        joy_select <= 1'b1;
                    end
                    S_PH6: begin
                        sh_xyzm    <= sync2[3:0];
                        state      <= S_PH7;
                        joy_select <= 1'b0;
                    end
                    S_PH7: begin
                        joy_out    <= sh_std;
                        is_md      <= md_flag;
                        is_6button <= md_flag & six_flag;
                        joy_start  <= md_flag ? sh_start : 1'b1;
                        joy_a      <= md_flag ? sh_a : 1'b1;
                        joy_xyzm   <= (md_flag & six_flag) ? sh_xyzm : 4'hF;
                        frame_done <= 1'b1;
                        state      <= S_IDLE;
                        cnt        <= IDLE_LOAD;
                        joy_select <= 1'b1;
                    end
                    default: begin
                        state      <= S_IDLE;
                        cnt        <= IDLE_LOAD;
                        joy_select <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_md_pad_scanner.sv
// Bench for md_pad_scanner: a behavioural DB9 pad model (plain stick, 3-button,
// 6-button) driven by SELECT, and a spec-level reference for the snapshot.

module tb_md_pad_scanner;

    localparam int P = 4;
    localparam int I = 20;
    localparam int FRAME = 8 * P + I;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] joy_raw;
    logic       joy_select;
    logic [5:0] joy_out;
    logic       joy_start;
    logic       joy_a;
    logic [3:0] joy_xyzm;
    logic       is_md;
    logic       is_6button;
    logic       frame_done;

    md_pad_scanner #(.PHASE_CYCLES(P), .IDLE_CYCLES(I)) dut (
        .clk        (clk),
        .rst        (rst),
        .joy_raw    (joy_raw),
        .joy_select (joy_select),
        .joy_out    (joy_out),
        .joy_start  (joy_start),
        .joy_a      (joy_a),
        .joy_xyzm   (joy_xyzm),
        .is_md      (is_md),
        .is_6button (is_6button),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Pad model. pad_type: 0 plain stick, 1 three-button, 2 six-button.
    // btn bits (1 = pressed): 0 R, 1 L, 2 D, 3 U, 4 B, 5 C, 6 A, 7 Start,
    // 8 Mode, 9 X, 10 Y, 11 Z.
    int          pad_type  = 0;
    logic [5:0]  plain_raw = 6'h3F;
    logic [11:0] btn       = '0;
    int          high_cnt  = 0;
    int          lowidx    = 0;

    always @(negedge clk) high_cnt <= joy_select ? high_cnt + 1 : 0;

    // A long SELECT-high stretch resets the pad's pulse counter.
    always @(negedge joy_select) lowidx <= (high_cnt > 8) ? 1 : lowidx + 1;

    always @* begin
        if (pad_type == 0) begin
            joy_raw = plain_raw;
        end else if (joy_select) begin
            if (pad_type == 2 && lowidx == 3 && high_cnt <= 8)
                joy_raw = {2'b11, ~btn[11], ~btn[10], ~btn[9], ~btn[8]};
            else
                joy_raw = ~{btn[5], btn[4], btn[3], btn[2], btn[1], btn[0]};
        end else begin
            if (pad_type == 2 && lowidx == 3)
                joy_raw = {~btn[7], ~btn[6], 4'b0000};
            else if (pad_type == 2 && lowidx == 4)
                joy_raw = {~btn[7], ~btn[6], 4'b1111};
            else
                joy_raw = {~btn[7], ~btn[6], ~btn[3], ~btn[2], 2'b00};
        end
    end

    // Reference: what the snapshot must show for the current pad and buttons.
    task automatic model(output logic [5:0] e_out, output logic e_start,
                         output logic e_a, output logic [3:0] e_xyzm,
                         output logic e_md, output logic e_six);
        if (pad_type == 0) begin
            e_out   = plain_raw;
            e_md    = (plain_raw[1:0] == 2'b00);
            e_six   = e_md && (plain_raw[3:0] == 4'h0);
            e_start = e_md ? plain_raw[5] : 1'b1;
            e_a     = e_md ? plain_raw[4] : 1'b1;
            e_xyzm  = e_six ? plain_raw[3:0] : 4'hF;
        end else begin
            e_out   = ~btn[5:0];
            e_md    = 1'b1;
            e_six   = (pad_type == 2);
            e_start = ~btn[7];
            e_a     = ~btn[6];
            e_xyzm  = e_six ? ~{btn[11], btn[10], btn[9], btn[8]} : 4'hF;
        end
    endtask

    task automatic check_model();
        logic [5:0] e_out;
        logic       e_start, e_a, e_md, e_six;
        logic [3:0] e_xyzm;
        model(e_out, e_start, e_a, e_xyzm, e_md, e_six);
        check("joy_out",    int'(joy_out),    int'(e_out));
        check("joy_start",  int'(joy_start),  int'(e_start));
        check("joy_a",      int'(joy_a),      int'(e_a));
        check("joy_xyzm",   int'(joy_xyzm),   int'(e_xyzm));
        check("is_md",      int'(is_md),      int'(e_md));
        check("is_6button", int'(is_6button), int'(e_six));
    endtask

    task automatic check_reset_vals();
        check("rst_joy_out",    int'(joy_out),    'h3F);
        check("rst_joy_start",  int'(joy_start),  1);
        check("rst_joy_a",      int'(joy_a),      1);
        check("rst_joy_xyzm",   int'(joy_xyzm),   'hF);
        check("rst_is_md",      int'(is_md),      0);
        check("rst_is_6button", int'(is_6button), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_joy_select", int'(joy_select), 1);
    endtask

    task automatic wait_frame(output int c);
        c = 0;
        do begin
            @(posedge clk); #1;
            c++;
        end while (!frame_done && c < 4 * FRAME);
        if (!frame_done) check("frame_timeout", 0, 1);
    endtask

    // Waits for the next commit, checks it, then checks the strobe width.
    task automatic run_frame(input bit chk_period);
        int c;
        wait_frame(c);
        if (chk_period) check("period", c, FRAME - 1);
        check_model();
        @(posedge clk); #1;
        check("fd_width", int'(frame_done), 0);
    endtask

    function automatic logic [11:0] legal_buttons(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        if (r[3] && r[2]) r[2] = 1'b0;
        if (r[1] && r[0]) r[0] = 1'b0;
        return r;
    endfunction

    initial begin
        int first_done;
        int c;
        logic [5:0] old_raw;
        logic       exp_sel;

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();

        // Release reset and trace SELECT through the first frame.
        rst = 1'b0;
        first_done = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (k < I || k >= FRAME) exp_sel = 1'b1;
            else exp_sel = (((k - I) / P) % 2) == 0;
            check("joy_select", int'(joy_select), int'(exp_sel));
            check("frame_done", int'(frame_done), int'(k == FRAME));
            if (frame_done) begin
                first_done = k;
                check("first_joy_out", int'(joy_out), 'h3F);
                check("first_is_md",   int'(is_md),   0);
            end
        end
        check("first_done_cycle", first_done, FRAME);

        // Plain stick with fire1 and right pressed.
        plain_raw = 6'b101110;
        run_frame(1'b0);

        // 3-button pad: A + Start + Up.
        pad_type = 1;
        btn = 12'b0000_1100_1000;
        run_frame(1'b1);

        // 6-button pad: X + Mode.
        pad_type = 2;
        btn = 12'b0011_0000_0000;
        run_frame(1'b1);

        // Randomised pads and sticks.
        for (int n = 0; n < 20; n++) begin
            pad_type  = $urandom_range(0, 2);
            btn       = legal_buttons(12'($urandom));
            plain_raw = 6'($urandom);
            run_frame(1'b1);
        end

        // Reset in PH5 with a 6-button pad pressing buttons.
        pad_type = 2;
        btn = legal_buttons(12'($urandom) | 12'h301);
        repeat (40) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_vals();
        rst = 1'b0;
        wait_frame(c);
        check("post_rst_done", c, FRAME);
        check_model();
        @(posedge clk); #1;
        check("fd_width", int'(frame_done), 0);

        // Input change after PH0 sampling stays out of the current commit.
        pad_type  = 0;
        old_raw   = 6'b101110;
        plain_raw = old_raw;
        repeat (24) @(posedge clk);
        #1;
        plain_raw = 6'b011101;
        wait_frame(c);
        check("mid_joy_out", int'(joy_out), int'(old_raw));
        check("mid_is_md",   int'(is_md),   0);
        @(posedge clk); #1;
        check("mid_fd_width", int'(frame_done), 0);
        repeat (20) @(posedge clk);
        #1;
        check("hold_joy_out", int'(joy_out), int'(old_raw));
        run_frame(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
